// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    MISS_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small power-of-two FIFO of {pc, instr} pairs with synchronous flush
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [31:0]                  push_pc_i,
  input  logic [31:0]                  push_instr_i,
  input  logic                         pop_i,
  output logic [31:0]                  head_pc_o,
  output logic [31:0]                  head_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // Flush shares the reset path so it wins over a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= {push_pc_i, push_instr_i};
  end

  assign head_pc_o    = mem_q[rd_q][63:32];
  assign head_instr_o = mem_q[rd_q][31:0];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with miss hold, redirect and decode buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_valid,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] count;
  logic          push, pop, flush, accept;

  always_comb begin
    ic_valid  = rst_n && ((state_q == MISS_WAIT) || ((state_q == RUN) && (count < DEPTH_C)));
    ic_addr   = pc_q;
    out_valid = rst_n && (count != '0);
    accept    = ic_valid && ic_ready;
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    flush     = redirect_valid;
    push      = 1'b0;
    pop       = out_valid && out_ready && !redirect_valid;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d = align_pc(redirect_pc);
        end else if (accept) begin
          push = 1'b1;
          pc_d = pc_q + INSTR_BYTES;
        end else if (ic_valid) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        // The address must not move until the refill completes, so a redirect
        // here is parked and applied once ic_ready arrives.
        if (ic_ready) begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
          end else if (pend_q) begin
            pc_d = tgt_q;
          end else begin
            push = 1'b1;
            pc_d = pc_q + INSTR_BYTES;
          end
        end else if (redirect_valid) begin
          tgt_d  = align_pc(redirect_pc);
          pend_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= align_pc(RESET_PC);
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_instr_i (ic_rdata),
    .pop_i        (pop),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr),
    .count_o      (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_valid;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Cache model: the word at an address is the address tagged with K.
  assign ic_rdata = ic_addr ^ K;

  fetch_unit #(.RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_valid       (ic_valid),
    .ic_addr        (ic_addr),
    .ic_ready       (ic_ready),
    .ic_rdata       (ic_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic ordy);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ic_ready = rdy; out_ready = ordy;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic goto(input logic [31:0] a);
    redirect_valid = 1'b1; redirect_pc = a;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ic_ready = 1'b1; out_ready = 1'b1;
    tick(); tick();
    checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL reset_ic_valid got=%b want=0", ic_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1; #1;
    checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h100) begin errors++; $display("FAIL seq_addr0 got=%b/%h want=1/100", ic_valid, ic_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_out0 got=%b want=0", out_valid); end
    tick();
    checks++; if (ic_addr !== 32'h104) begin errors++; $display("FAIL seq_addr1 got=%h want=104", ic_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL seq_out1 got=%b/%h/%h want=1/100/%h", out_valid, out_pc, out_instr, 32'h100 ^ K); end
    tick();
    checks++; if (ic_addr !== 32'h108) begin errors++; $display("FAIL seq_addr2 got=%h want=108", ic_addr); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errors++; $display("FAIL seq_out2 got=%b/%h want=1/104", out_valid, out_pc); end
  endtask

  task automatic test_stall();
    do_reset(1'b1, 1'b0);
    tick(); tick();
    checks++; if (ic_valid !== 1'b0 || ic_addr !== 32'h108) begin errors++; $display("FAIL stall_full got=%b/%h want=0/108", ic_valid, ic_addr); end
    tick();
    checks++; if (ic_valid !== 1'b0 || ic_addr !== 32'h108 || out_pc !== 32'h100) begin errors++; $display("FAIL stall_hold got=%b/%h/%h want=0/108/100", ic_valid, ic_addr, out_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h108 || out_pc !== 32'h104) begin errors++; $display("FAIL stall_release got=%b/%h/%h want=1/108/104", ic_valid, ic_addr, out_pc); end
    tick();
    checks++; if (ic_addr !== 32'h10C || out_pc !== 32'h108 || out_instr !== (32'h108 ^ K)) begin errors++; $display("FAIL stall_resume got=%h/%h/%h want=10c/108/%h", ic_addr, out_pc, out_instr, 32'h108 ^ K); end
  endtask

  task automatic test_miss();
    do_reset(1'b0, 1'b1);
    goto(32'h200);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h200 || out_valid !== 1'b0) begin errors++; $display("FAIL miss_hold%0d got=%b/%h/%b want=1/200/0", i, ic_valid, ic_addr, out_valid); end
      tick();
    end
    ic_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== (32'h200 ^ K) || ic_addr !== 32'h204) begin errors++; $display("FAIL miss_done got=%b/%h/%h/%h want=1/200/%h/204", out_valid, out_pc, out_instr, ic_addr, 32'h200 ^ K); end
  endtask

  task automatic test_redirect_in_miss();
    do_reset(1'b0, 1'b1);
    goto(32'h200);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ic_addr !== 32'h200 || ic_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmiss_hold%0d got=%h/%b/%b want=200/1/0", i, ic_addr, ic_valid, out_valid); end
      tick();
    end
    ic_ready = 1'b1;
    tick();
    checks++; if (ic_addr !== 32'h400 || out_valid !== 1'b0) begin errors++; $display("FAIL rmiss_target got=%h/%b want=400/0", ic_addr, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin errors++; $display("FAIL rmiss_out got=%b/%h want=1/400", out_valid, out_pc); end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b1, 1'b0);
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || ic_valid !== 1'b0) begin errors++; $display("FAIL rfull_pre got=%b/%b want=1/0", out_valid, ic_valid); end
    out_ready = 1'b1;
    goto(32'h303);
    checks++; if (out_valid !== 1'b0 || ic_valid !== 1'b1 || ic_addr !== 32'h300) begin errors++; $display("FAIL rfull_flush got=%b/%b/%h want=0/1/300", out_valid, ic_valid, ic_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin errors++; $display("FAIL rfull_out got=%b/%h want=1/300", out_valid, out_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b1);
    goto(32'hFFFF_FFFC);
    checks++; if (ic_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_pre got=%h/%b want=fffffffc/0", ic_addr, out_valid); end
    tick();
    checks++; if (ic_addr !== 32'h0 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_next got=%h/%h want=0/fffffffc", ic_addr, out_pc); end
  endtask

  task automatic test_reset_mid_miss();
    do_reset(1'b0, 1'b1);
    goto(32'h200);
    tick(); tick();
    rst_n = 1'b0; #1;
    checks++; if (ic_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmiss_low got=%b/%b want=0/0", ic_valid, out_valid); end
    tick();
    rst_n = 1'b1; #1;
    checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h100 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmiss_restart got=%b/%h/%b want=1/100/0", ic_valid, ic_addr, out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_miss();
    test_redirect_in_miss();
    test_redirect_full();
    test_wrap();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
